// File: rtl/regfile_2w2r.sv
// Two-write / two-read register file with registered, write-through reads and a DEPTH-cycle clear sweep.
// Build option: define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_2w2r #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic              clr_req,
  output logic              clr_busy
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] nxt  [DEPTH];
  logic [DATA_W-1:0] rd_nxt_a, rd_nxt_b;
  logic              ok0, ok1;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          idx_nxt   = '0;
        end
      end
      CLEAR: begin
        if (idx == LAST_IDX) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Out-of-range write addresses match no entry below and so drop out naturally.
  always_comb begin
    ok0 = wr_en0 && (state == IDLE) && !(ZERO_REG && (wr_addr0 == '0));
    ok1 = wr_en1 && (state == IDLE) && !(ZERO_REG && (wr_addr1 == '0));
    nxt = regs;
    for (int i = 0; i < DEPTH; i++) begin
      if ((state == CLEAR) && (idx == ADDR_W'(i)))
        nxt[i] = '0;
      else if (ok1 && (wr_addr1 == ADDR_W'(i)))
        nxt[i] = wr_data1;
      else if (ok0 && (wr_addr0 == ADDR_W'(i)))
        nxt[i] = wr_data0;
    end
    // Reads sample the post-edge array, so same-edge writes and clears are visible.
    rd_nxt_a = '0;
    rd_nxt_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr_a == ADDR_W'(i)) rd_nxt_a = nxt[i];
      if (rd_addr_b == ADDR_W'(i)) rd_nxt_b = nxt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      regs      <= '{default: '0};
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      regs      <= nxt;
      rd_data_a <= rd_nxt_a;
      rd_data_b <= rd_nxt_b;
    end
  end

  assign clr_busy = (state == CLEAR);

endmodule

// File: doc/regfile_2w2r.md
Name: regfile_2w2r

Overview:
- Parametrised successor to the single-write register file used by the datapath.
- Two write ports and two read ports; reads are registered and see same-edge writes.
- Adds an asynchronous active-low reset that clears the array, plus a multi-cycle clear sweep that the control unit requests.
- Sits between decode (read addresses), writeback (two retire lanes) and the operand latches of the ALU.

Parameters:
- DATA_W, 20, width of each register and of all data ports.
- ADDR_W, 4, width of all address ports.
- DEPTH, 16, number of implemented registers; legal range 2 to 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_addr_b  in  ADDR_W  read port B address.
- rd_data_a  out  DATA_W  registered read data A.
- rd_data_b  out  DATA_W  registered read data B.
- wr_en0  in  1  write enable, lane 0.
- wr_addr0  in  ADDR_W  write address, lane 0.
- wr_data0  in  DATA_W  write data, lane 0.
- wr_en1  in  1  write enable, lane 1.
- wr_addr1  in  ADDR_W  write address, lane 1.
- wr_data1  in  DATA_W  write data, lane 1.
- clr_req  in  1  single-cycle request to start a clear sweep.
- clr_busy  out  1  high while the clear sweep runs.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-sweep):
  - all DEPTH registers become 0.
  - rd_data_a and rd_data_b become 0.
  - clr_busy becomes 0.
  - FSM goes to IDLE and the sweep index goes to 0.
- Read latency is 1 cycle. On each rising edge, rd_data_x takes the content of rd_addr_x including any write committed on that same edge (write-then-read).
- Read address >= DEPTH: rd_data_x <= 0 on the next edge.
- Writes commit on the rising edge when wr_enN=1 and the FSM is in IDLE.
  - Write address >= DEPTH: the write is silently dropped.
- Both lanes enabled with equal addresses: lane 1 wins, for both the stored value and the same-edge read bypass.
- FSM states:
  - IDLE: clr_busy=0. If clr_req=1, go to CLEAR with index=0. Writes that arrive in the same cycle as clr_req still commit.
  - CLEAR: clr_busy=1. Each edge sets register[index] to 0 and increments index. After index DEPTH-1 is cleared, return to IDLE. The sweep occupies exactly DEPTH cycles of clr_busy=1.
  - In CLEAR, wr_en0 and wr_en1 are ignored (no commit, no bypass).
  - Reads continue every cycle and return current array contents. Already-cleared entries read 0; not-yet-cleared entries keep their old values.
  - clr_req while in CLEAR is ignored; the sweep does not restart.
- No combinational path from any input to any output.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined: register 0 is hardwired to 0.
  - Writes to address 0 on either lane are discarded, and are not bypassed to same-edge reads.
  - Reads of address 0 always return 0.
  - If the other lane targets a nonzero address in the same cycle, that write proceeds normally.
- Not defined: register 0 is an ordinary register.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle after writing 20'hABCDE to r5 -> outputs go to 0 immediately. Release reset, read r5 -> rd_data_a=0 one edge later.
- Same-edge bypass: wr_en0=1, wr_addr0=3, wr_data0=20'h12345, rd_addr_a=3, all on one edge -> rd_data_a=20'h12345 after that edge.
- Dual-write collision: both lanes write addr 7, lane0=20'h00001, lane1=20'h00002 -> read of r7 returns 20'h00002; rd_data_b bypass on that edge also shows 20'h00002.
- Independent dual write: lane0 writes r1=20'h11111, lane1 writes r2=20'h22222, same edge -> next cycle, A reads r1=20'h11111 and B reads r2=20'h22222.
- Clear sweep: fill r0..r15 with 20'hFFFFF, pulse clr_req.
  - clr_busy stays high exactly 16 cycles.
  - A write of r9=20'h55555 during the sweep is ignored.
  - Reading r15 at sweep cycle 10 returns 20'hFFFFF.
  - After the sweep, all registers read 0.
  - A second clr_req pulse at cycle 4 has no effect.
- Out-of-range (DEPTH=12): write r13=20'h77777, then read r13 -> 0; r0..r11 unchanged. With REGFILE_ZERO_REG_EN defined, write r0=20'h99999 -> reading r0 returns 0.
